// File: rtl/vend_ctrl_n.sv
// vend_ctrl_n: multi-item vending controller.
// Coins of 1/5/10 units accumulate into a saturating credit register. A buy
// dispenses one item for price(i) = PRICE_BASE + i*PRICE_STEP. Change is paid
// back greedily as 5-unit then 1-unit pulses, and cancel refunds the credit.
// Optional feature macro: VEND_STOCK_EN adds per-item stock counters and
// sold-out flags. Without it, sold_out is tied low and stock never blocks a buy.
module vend_ctrl_n #(
    parameter int NUM_ITEMS  = 4,
    parameter int SEL_W      = 2,
    parameter int CREDIT_W   = 6,
    parameter int PRICE_BASE = 3,
    parameter int PRICE_STEP = 2,
    parameter int STOCK_W    = 4,
    parameter int STOCK_INIT = 15
) (
    input  logic                 clk,
    input  logic                 R,
    input  logic                 P1,
    input  logic                 P5,
    input  logic                 P10,
    input  logic [SEL_W-1:0]     sel,
    input  logic                 buy,
    input  logic                 cancel,
    output logic                 item,
    output logic [SEL_W-1:0]     item_id,
    output logic                 change5,
    output logic                 change1,
    output logic                 reject,
    output logic                 err,
    output logic                 busy,
    output logic [CREDIT_W-1:0]  credit,
    output logic [NUM_ITEMS-1:0] sold_out
);

    // Price and coin arithmetic is one bit wider than credit so overflow is visible.
    localparam int CW1 = CREDIT_W + 1;
    localparam logic [CW1-1:0] MAX_CREDIT = {1'b0, {CREDIT_W{1'b1}}};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_VEND   = 2'd1,
        ST_CHANGE = 2'd2
    } state_t;

    state_t                state_q;
    logic [CREDIT_W-1:0]   credit_q;
    logic                  p1_hist_q;
    logic                  p5_hist_q;
    logic                  p10_hist_q;
    logic                  item_q;
    logic [SEL_W-1:0]      item_id_q;
    logic                  change5_q;
    logic                  change1_q;
    logic                  reject_q;
    logic                  err_q;
    logic                  busy_q;

    logic                  edge1_s;
    logic                  edge5_s;
    logic                  edge10_s;
    logic                  coin_any_s;
    logic                  coin_multi_s;
    logic [CW1-1:0]        coin_val_s;
    logic [CW1-1:0]        coin_sum_s;
    logic                  coin_fits_s;
    logic [31:0]           sel_wide_s;
    logic [CW1-1:0]        price_s;
    logic                  sel_ok_s;
    logic                  sold_sel_s;
    logic                  buy_ok_s;
    logic                  change_big_s;
    logic [CREDIT_W-1:0]   change_credit_s;
    logic [NUM_ITEMS-1:0]  sold_out_s;

    // Coin edge decode, greedy coin priority and buy qualification.
    always_comb begin
        edge1_s      = P1  & ~p1_hist_q;
        edge5_s      = P5  & ~p5_hist_q;
        edge10_s     = P10 & ~p10_hist_q;
        coin_any_s   = edge1_s | edge5_s | edge10_s;
        coin_multi_s = (edge10_s & edge5_s) | (edge10_s & edge1_s) | (edge5_s & edge1_s);
        if (edge10_s) begin
            coin_val_s = CW1'(10);
        end else if (edge5_s) begin
            coin_val_s = CW1'(5);
        end else if (edge1_s) begin
            coin_val_s = CW1'(1);
        end else begin
            coin_val_s = {CW1{1'b0}};
        end
        coin_sum_s  = {1'b0, credit_q} + coin_val_s;
        coin_fits_s = (coin_sum_s <= MAX_CREDIT);

        sel_wide_s  = 32'(sel);
        price_s     = CW1'(PRICE_BASE + sel_wide_s * PRICE_STEP);
        sel_ok_s    = (sel_wide_s < NUM_ITEMS);
        if (sel_ok_s) begin
            sold_sel_s = sold_out_s[sel];
        end else begin
            sold_sel_s = 1'b0;
        end
        // A price above MAX_CREDIT can never be covered, so that item always errs.
        buy_ok_s = sel_ok_s & (price_s <= MAX_CREDIT) &
                   ({1'b0, credit_q} >= price_s) & ~sold_sel_s;

        change_big_s = (credit_q >= CREDIT_W'(5));
        if (change_big_s) begin
            change_credit_s = credit_q - CREDIT_W'(5);
        end else begin
            change_credit_s = credit_q - CREDIT_W'(1);
        end
    end

    // Main FSM: credit, coin history and all registered pulse outputs.
    always_ff @(posedge clk or negedge R) begin
        if (!R) begin
            state_q    <= ST_IDLE;
            credit_q   <= {CREDIT_W{1'b0}};
            p1_hist_q  <= 1'b0;
            p5_hist_q  <= 1'b0;
            p10_hist_q <= 1'b0;
            item_q     <= 1'b0;
            item_id_q  <= {SEL_W{1'b0}};
            change5_q  <= 1'b0;
            change1_q  <= 1'b0;
            reject_q   <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            p1_hist_q  <= P1;
            p5_hist_q  <= P5;
            p10_hist_q <= P10;
            item_q     <= 1'b0;
            item_id_q  <= {SEL_W{1'b0}};
            change5_q  <= 1'b0;
            change1_q  <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            // Any coin edge is refused unless the IDLE coin-only path takes it.
            reject_q   <= coin_any_s;
            case (state_q)
                ST_IDLE: begin
                    if (buy) begin
                        if (buy_ok_s) begin
                            credit_q  <= credit_q - price_s[CREDIT_W-1:0];
                            item_q    <= 1'b1;
                            item_id_q <= sel;
                            busy_q    <= 1'b1;
                            state_q   <= ST_VEND;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end else if (cancel && (credit_q != {CREDIT_W{1'b0}})) begin
                        // The first refund pulse leaves on the same edge as the cancel.
                        change5_q <= change_big_s;
                        change1_q <= ~change_big_s;
                        credit_q  <= change_credit_s;
                        busy_q    <= 1'b1;
                        state_q   <= ST_CHANGE;
                    end else if (coin_any_s) begin
                        if (coin_fits_s) begin
                            credit_q <= coin_sum_s[CREDIT_W-1:0];
                        end else begin
                            credit_q <= credit_q;
                        end
                        reject_q <= coin_multi_s | ~coin_fits_s;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_VEND: begin
                    if (credit_q != {CREDIT_W{1'b0}}) begin
                        change5_q <= change_big_s;
                        change1_q <= ~change_big_s;
                        credit_q  <= change_credit_s;
                        busy_q    <= 1'b1;
                        state_q   <= ST_CHANGE;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_CHANGE: begin
                    if (credit_q != {CREDIT_W{1'b0}}) begin
                        change5_q <= change_big_s;
                        change1_q <= ~change_big_s;
                        credit_q  <= change_credit_s;
                        busy_q    <= 1'b1;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef VEND_STOCK_EN
    logic [STOCK_W-1:0]   stock_q [NUM_ITEMS];
    logic [NUM_ITEMS-1:0] sold_out_q;

    // Per-item stock: the dispensed item's counter drops during its VEND cycle.
    always_ff @(posedge clk or negedge R) begin
        if (!R) begin
            for (int i = 0; i < NUM_ITEMS; i++) begin
                stock_q[i] <= STOCK_W'(STOCK_INIT);
            end
            sold_out_q <= {NUM_ITEMS{(STOCK_W'(STOCK_INIT) == {STOCK_W{1'b0}})}};
        end else if (state_q == ST_VEND) begin
            for (int i = 0; i < NUM_ITEMS; i++) begin
                if ((SEL_W'(i) == item_id_q) && (stock_q[i] != {STOCK_W{1'b0}})) begin
                    stock_q[i]    <= stock_q[i] - STOCK_W'(1);
                    sold_out_q[i] <= (stock_q[i] == STOCK_W'(1));
                end else begin
                    stock_q[i]    <= stock_q[i];
                end
            end
        end else begin
            sold_out_q <= sold_out_q;
        end
    end

    assign sold_out_s = sold_out_q;
`else
    assign sold_out_s = {NUM_ITEMS{1'b0}};
`endif

    assign item     = item_q;
    assign item_id  = item_id_q;
    assign change5  = change5_q;
    assign change1  = change1_q;
    assign reject   = reject_q;
    assign err      = err_q;
    assign busy     = busy_q;
    assign credit   = credit_q;
    assign sold_out = sold_out_s;

endmodule

// File: doc/vend_ctrl_n.md
# vend_ctrl_n

Parametrised multi-item vending controller, the successor to the single-item, fixed-price vending machine. It accepts 1/5/10-unit coins into a saturating credit register and serves NUM_ITEMS items, each with its own derived price. It dispenses one selected item per purchase, returns change greedily as 5-unit then 1-unit pulses, and supports cancel/refund. It sits between the debounced coin/button front end and the dispenser and change-hopper drivers.

## Interface
- NUM_ITEMS, 4: item channels; legal `sel` values are 0..NUM_ITEMS-1.
- SEL_W, 2: width of `sel` and `item_id`.
- CREDIT_W, 6: credit width; MAX_CREDIT = 2^CREDIT_W-1 (63).
- PRICE_BASE, 3: price of item 0.
- PRICE_STEP, 2: per-item increment; price(i) = PRICE_BASE + i*PRICE_STEP (3, 5, 7, 9 by default).
- STOCK_W, 4: stock counter width (VEND_STOCK_EN only).
- STOCK_INIT, 15: per-item stock after reset (VEND_STOCK_EN only).

- clk  in  1  system clock; all logic is on the rising edge.
- R  in  1  reset, asynchronous, active-low.
- P1, P5, P10  in  1 each  coin inputs; each 0->1 transition sampled on `clk` is one coin of 1, 5 or 10 units.
- sel  in  SEL_W  item selection, sampled with `buy`.
- buy  in  1  purchase request, 1-cycle pulse.
- cancel  in  1  refund request, 1-cycle pulse.
- item  out  1  1-cycle dispense pulse.
- item_id  out  SEL_W  item number, valid while `item`=1.
- change5, change1  out  1 each  1-cycle change pulses worth 5 and 1 units.
- reject  out  1  1-cycle pulse: a coin was not accepted and goes to the return chute.
- err  out  1  1-cycle pulse: a buy request was refused.
- busy  out  1  high in VEND and CHANGE.
- credit  out  CREDIT_W  current credit register.
- sold_out  out  NUM_ITEMS  per-item empty flags.

## Operation
- States:
  - IDLE: accumulate coins and accept requests.
  - VEND: one cycle; `item` pulses.
  - CHANGE: pay out the remaining credit.
- Coin edge detection uses a 1-flop history per input. Several coin edges in one cycle: P10 > P5 > P1; one edge is accepted and `reject` pulses once for the rest.
- IDLE, coin only: credit += value, provided the result ≤ MAX_CREDIT. Otherwise the credit is unchanged and `reject` pulses.
- IDLE, buy: `buy` has priority over `cancel`. Any coin arriving in the same cycle is rejected. The buy is evaluated against the registered credit.
  - sel ≥ NUM_ITEMS, credit < price(sel), or item sold out: `err` pulses; credit and state are unchanged.
  - Otherwise: credit -= price(sel) and the FSM enters VEND.
- IDLE, cancel: with credit > 0, go to CHANGE. With credit = 0, nothing happens (no `err`).
- VEND -> CHANGE if the remaining credit > 0, else -> IDLE.
- CHANGE: each cycle, if credit ≥ 5 pulse `change5` and subtract 5; else pulse `change1` and subtract 1. When credit reaches 0, return to IDLE.
- Coins arriving in VEND or CHANGE are rejected. `buy` and `cancel` are ignored in VEND and CHANGE (no `err`).
- Price arithmetic is done at CREDIT_W+1 bits. A price(i) > MAX_CREDIT makes that item unobtainable: every buy of it gives `err`.

## Timing
- Reset (R=0) takes effect immediately, including mid-VEND or mid-CHANGE. The pending change is forfeited.
- Reset values: state IDLE; credit 0; item, item_id, change5, change1, reject, err and busy all 0; coin history 0.
- sold_out is 0 after reset, or reflects STOCK_INIT=0 under VEND_STOCK_EN.
- All outputs are registered.
- Coin edge sampled at edge k: `credit` updates and/or `reject` is high in cycle k+1.
- `buy` sampled at edge k: `item` is high in cycle k+1 (or `err` is high in k+1). The first change pulse is in k+2, followed by one pulse per cycle with no gaps.
- `cancel` at edge k: the first change pulse is in k+1.
- `busy` covers exactly the VEND and CHANGE cycles. The next coin is accepted from the first IDLE cycle.

## Configuration
- VEND_STOCK_EN defined:
  - Each item has a STOCK_W-bit counter, reset to STOCK_INIT.
  - A successful buy decrements that item's counter in the VEND cycle.
  - sold_out[i] = (stock[i] == 0).
  - A buy of a sold-out item gives `err`.
- VEND_STOCK_EN undefined: no counters are built, sold_out is tied to 0, and stock never blocks a buy.

## Test plan
- Reset: hold R=0 with coins toggling -> every output stays 0 and credit stays 0. Release, then P1 -> credit=1 one cycle later.
- P1, P1, P1, then buy sel=0 -> `item` pulses once with item_id=0, no change pulses, credit=0, busy high for 1 cycle.
- P1, P1, P5 (7), then buy sel=0 -> `item`, then change1×4 on consecutive cycles, credit 4→0.
- P10, P10 (20), then buy sel=3 (price 9) -> `item`, change5, change5, change1; busy high for 4 cycles.
- P1 (credit 1), then buy sel=1 -> `err`, credit stays 1. Then P5 and cancel -> change5, change1. P5 with credit=60 -> `reject`, credit stays 60. R low mid-CHANGE -> change pulses stop immediately and credit=0.
- VEND_STOCK_EN, STOCK_INIT=1: two funded buys of sel=2 -> the first gives `item` and sets sold_out[2]=1; the second gives `err` and credit is unchanged.
